// File: rtl/stack_buffer_if.sv
// Bus bundle for stack_buffer: producer/consumer strobes in, top-of-stack and status out.
// master = the side issuing push/pop/clr, slave = the stack itself.
interface stack_buffer_if #(
    parameter int B = 8,
    parameter int W = 2
);
    // push/pop/clr are single-cycle strobes sampled on the rising clock edge.
    // There is no ready/back-pressure: an illegal push (full) or pop (empty) is
    // dropped and recorded in the sticky overflow/underflow flags instead.
    logic         clr;
    logic         push;
    logic         pop;
    logic [B-1:0] w_data;
    logic [B-1:0] r_data;
    logic         empty;
    logic         full;
    logic         almost_full;
    logic [W:0]   count;
    logic         overflow;
    logic         underflow;
    logic [W:0]   max_count;

    modport master (
        output clr, push, pop, w_data,
        input  r_data, empty, full, almost_full, count, overflow, underflow, max_count
    );

    modport slave (
        input  clr, push, pop, w_data,
        output r_data, empty, full, almost_full, count, overflow, underflow, max_count
    );
endinterface

// File: rtl/stack_buffer.sv
// Parametrised show-ahead LIFO with replace-top, sticky error flags and synchronous clear.
// Define STACK_WATERMARK_EN to build the max_count high-water-mark register.
module stack_buffer #(
    parameter int B        = 8,
    parameter int W        = 2,
    parameter int AF_LEVEL = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    stack_buffer_if.slave  bus
);
    localparam int             D        = 2 ** W;
    localparam logic [W:0]     D_CNT    = (W+1)'(D);
    localparam logic [W:0]     AF_CNT   = (W+1)'(AF_LEVEL);
    localparam logic [W:0]     CNT_ONE  = (W+1)'(1);
    localparam logic [W-1:0]   ADDR_ONE = W'(1);

    logic [B-1:0] mem_q [D];
    logic [W:0]   count_q, count_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_en;
    logic [W-1:0] wr_addr;
    logic [W-1:0] top_addr;
    logic         is_empty, is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == D_CNT);
    // When count == D the low bits wrap to 0, so top_addr still lands on D-1.
    assign top_addr = count_q[W-1:0] - ADDR_ONE;

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_addr     = count_q[W-1:0];
        if (bus.clr) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            case ({bus.push, bus.pop})
                2'b10: begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (!is_empty) begin
                        count_d = count_q - CNT_ONE;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    wr_en = 1'b1;
                    if (!is_empty) begin
                        wr_addr = top_addr;
                    end else begin
                        count_d = CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= bus.w_data;
        end
    end

`ifdef STACK_WATERMARK_EN
    logic [W:0] max_q, max_d;

    always_comb begin
        max_d = max_q;
        if (bus.clr) begin
            max_d = '0;
        end else if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign bus.max_count = max_q;
`else
    assign bus.max_count = '0;
`endif

    assign bus.r_data      = is_empty ? '0 : mem_q[top_addr];
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.almost_full = (count_q >= AF_CNT);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_stack_buffer.sv
// Directed self-checking bench for stack_buffer (B=8, W=2, D=4, AF_LEVEL=3).
// Works in both builds; watermark expectations follow STACK_WATERMARK_EN.
module tb_stack_buffer;
    localparam int B = 8;
    localparam int W = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    stack_buffer_if #(.B(B), .W(W)) bus ();

    stack_buffer #(.B(B), .W(W), .AF_LEVEL(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Apply one cycle of strobes, then sample 1ns after the capturing edge.
    task automatic do_op(input logic p, input logic q, input logic [B-1:0] d, input logic c);
        bus.push   = p;
        bus.pop    = q;
        bus.w_data = d;
        bus.clr    = c;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic test_reset();
        bus.push = 0; bus.pop = 0; bus.clr = 0; bus.w_data = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        total++; if (bus.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL reset_err got=%b%b exp=00", bus.overflow, bus.underflow); end
        total++; if (bus.r_data !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus.r_data); end
        total++; if (bus.max_count !== 3'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", bus.max_count); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_fill();
        logic [B-1:0] vals   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [W:0]   exp_c  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic         exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic         exp_f  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(1, 0, vals[i], 0);
            total++; if (bus.count !== exp_c[i]) begin bad++; $display("FAIL push_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); end
            total++; if (bus.r_data !== vals[i]) begin bad++; $display("FAIL push_rdata[%0d] got=%h exp=%h", i, bus.r_data, vals[i]); end
            total++; if (bus.almost_full !== exp_af[i]) begin bad++; $display("FAIL push_af[%0d] got=%b exp=%b", i, bus.almost_full, exp_af[i]); end
            total++; if (bus.full !== exp_f[i]) begin bad++; $display("FAIL push_full[%0d] got=%b exp=%b", i, bus.full, exp_f[i]); end
            total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL push_empty[%0d] got=%b exp=0", i, bus.empty); end
        end
    endtask

    task automatic test_overflow_pop();
        logic [B-1:0] exp_r [4] = '{8'h33, 8'h22, 8'h11, 8'h00};
        logic [W:0]   exp_c [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
        logic         exp_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_op(1, 0, 8'h55, 0);
        total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d exp=4", bus.count); end
        total++; if (bus.r_data !== 8'h44) begin bad++; $display("FAIL ovf_rdata got=%h exp=44", bus.r_data); end
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        for (int i = 0; i < 4; i++) begin
            do_op(0, 1, 8'h00, 0);
            total++; if (bus.r_data !== exp_r[i]) begin bad++; $display("FAIL pop_rdata[%0d] got=%h exp=%h", i, bus.r_data, exp_r[i]); end
            total++; if (bus.count !== exp_c[i]) begin bad++; $display("FAIL pop_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); end
            total++; if (bus.empty !== exp_e[i]) begin bad++; $display("FAIL pop_empty[%0d] got=%b exp=%b", i, bus.empty, exp_e[i]); end
        end
        total++; if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin bad++; $display("FAIL ovf_sticky got=%b%b exp=10", bus.overflow, bus.underflow); end
    endtask

    task automatic test_underflow();
        do_op(0, 1, 8'h00, 0);
        total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL unf_count got=%0d exp=0", bus.count); end
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", bus.underflow); end
        do_op(1, 1, 8'hA5, 0);
        total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL pp_empty_count got=%0d exp=1", bus.count); end
        total++; if (bus.r_data !== 8'hA5) begin bad++; $display("FAIL pp_empty_rdata got=%h exp=a5", bus.r_data); end
        total++; if (bus.underflow !== 1'b1) begin bad++; $display("FAIL unf_sticky got=%b exp=1", bus.underflow); end
        do_op(0, 0, 8'h00, 1);
        do_op(1, 1, 8'h5A, 0);
        total++; if (bus.underflow !== 1'b0) begin bad++; $display("FAIL pp_empty_nounf got=%b exp=0", bus.underflow); end
        total++; if (bus.count !== 3'd1 || bus.r_data !== 8'h5A) begin bad++; $display("FAIL pp_empty2 got=%0d/%h exp=1/5a", bus.count, bus.r_data); end
    endtask

    task automatic test_replace_top();
        do_op(0, 0, 8'h00, 1);
        do_op(1, 0, 8'h11, 0);
        do_op(1, 0, 8'h22, 0);
        do_op(1, 1, 8'h99, 0);
        total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL rep_count got=%0d exp=2", bus.count); end
        total++; if (bus.r_data !== 8'h99) begin bad++; $display("FAIL rep_rdata got=%h exp=99", bus.r_data); end
        do_op(0, 1, 8'h00, 0);
        total++; if (bus.r_data !== 8'h11) begin bad++; $display("FAIL rep_pop_rdata got=%h exp=11", bus.r_data); end
        do_op(1, 0, 8'h22, 0);
        do_op(1, 0, 8'h33, 0);
        do_op(1, 0, 8'h44, 0);
        do_op(1, 1, 8'h77, 0);
        total++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin bad++; $display("FAIL rep_full_count got=%0d/%b exp=4/1", bus.count, bus.full); end
        total++; if (bus.r_data !== 8'h77) begin bad++; $display("FAIL rep_full_rdata got=%h exp=77", bus.r_data); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rep_full_noovf got=%b exp=0", bus.overflow); end
        do_op(0, 1, 8'h00, 0);
        total++; if (bus.r_data !== 8'h33) begin bad++; $display("FAIL rep_full_pop got=%h exp=33", bus.r_data); end
    endtask

    task automatic test_clr_reset();
        do_op(0, 0, 8'h00, 1);
        do_op(0, 1, 8'h00, 0);
        for (int i = 0; i < 5; i++) do_op(1, 0, 8'h60 + 8'(i), 0);
        do_op(0, 1, 8'h00, 0);
        total++; if (bus.count !== 3'd3 || bus.overflow !== 1'b1 || bus.underflow !== 1'b1) begin
            bad++; $display("FAIL clr_setup got=%0d/%b%b exp=3/11", bus.count, bus.overflow, bus.underflow);
        end
        do_op(1, 0, 8'hEE, 1);
        total++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL clr_count got=%0d/%b exp=0/1", bus.count, bus.empty); end
        total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin bad++; $display("FAIL clr_err got=%b%b exp=00", bus.overflow, bus.underflow); end
        total++; if (bus.r_data !== 8'h00) begin bad++; $display("FAIL clr_rdata got=%h exp=00", bus.r_data); end
        do_op(1, 0, 8'hB1, 0);
        do_op(1, 0, 8'hB2, 0);
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%0d/%b/%b exp=0/1/0", bus.count, bus.empty, bus.full);
        end
        total++; if (bus.r_data !== 8'h00) begin bad++; $display("FAIL async_reset_rdata got=%h exp=00", bus.r_data); end
        #2 reset_n = 1'b1;
        do_op(1, 0, 8'hC3, 0);
        total++; if (bus.count !== 3'd1 || bus.r_data !== 8'hC3) begin bad++; $display("FAIL post_reset_push got=%0d/%h exp=1/c3", bus.count, bus.r_data); end
        do_op(1, 0, 8'hC4, 0);
        do_op(0, 1, 8'h00, 0);
        total++; if (bus.r_data !== 8'hC3) begin bad++; $display("FAIL post_reset_idx0 got=%h exp=c3", bus.r_data); end
    endtask

    task automatic test_watermark();
        logic         ops_push [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W:0]   exp_c    [6] = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2};
        logic [W:0]   exp_max  [6];
        logic [W:0]   exp_clr;
`ifdef STACK_WATERMARK_EN
        exp_max = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
`else
        exp_max = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`endif
        exp_clr = 3'd0;
        do_op(0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) begin
            do_op(ops_push[i], !ops_push[i], 8'hD0 + 8'(i), 0);
            total++; if (bus.count !== exp_c[i]) begin bad++; $display("FAIL wm_count[%0d] got=%0d exp=%0d", i, bus.count, exp_c[i]); end
            total++; if (bus.max_count !== exp_max[i]) begin bad++; $display("FAIL wm_max[%0d] got=%0d exp=%0d", i, bus.max_count, exp_max[i]); end
        end
        do_op(0, 0, 8'h00, 1);
        total++; if (bus.max_count !== exp_clr) begin bad++; $display("FAIL wm_clr got=%0d exp=%0d", bus.max_count, exp_clr); end
    endtask

    initial begin
        test_reset();
        test_push_fill();
        test_overflow_pop();
        test_underflow();
        test_replace_top();
        test_clr_reset();
        test_watermark();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
